// File: rtl/pipe_reg_hs.sv
// Elastic pipeline register: valid/ready handshake, main + skid storage, registered up_ready_o.
// Optional saturating stall/bubble counters are built only when PIPE_REG_HS_PERF_EN is defined.
module pipe_reg_hs #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [DW-1:0]    default_data_i,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [DW-1:0]    up_data_i,
  output logic             dn_valid_o,
  input  logic             dn_ready_i,
  output logic [DW-1:0]    dn_data_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] main_q, skid_q;
  logic          up_ready_q, dn_valid_q;
  logic          up_fire, dn_fire;
  logic          load_main_up, load_main_skid, load_skid;

  assign up_fire = up_valid_i & up_ready_q;
  assign dn_fire = dn_valid_q & dn_ready_i;

  // Handshake outputs get their own flops so neither depends combinationally on a port.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      up_ready_q <= (state_d != FULL);
      dn_valid_q <= (state_d != EMPTY);
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (up_fire) state_d = ONE;
        ONE: begin
          if (up_fire && !dn_fire)      state_d = FULL;
          else if (!up_fire && dn_fire) state_d = EMPTY;
        end
        FULL:    if (dn_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    load_main_up   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: load_main_up = up_fire;
      ONE: begin
        load_main_up = up_fire & dn_fire;
        load_skid    = up_fire & ~dn_fire;
      end
      FULL:    load_main_skid = dn_fire;
      default: ;
    endcase
  end

  assign up_ready_o = up_ready_q;
  assign dn_valid_o = dn_valid_q;
  assign dn_data_o  = main_q;

  // Flush outranks any load; a beat taken during a flush is simply never stored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q <= default_data_i;
      skid_q <= '0;
    end else begin
      if (flush_i)             main_q <= default_data_i;
      else if (load_main_up)   main_q <= up_data_i;
      else if (load_main_skid) main_q <= skid_q;
      if (!flush_i && load_skid) skid_q <= up_data_i;
    end
  end

`ifdef PIPE_REG_HS_PERF_EN
  logic [CNT_W-1:0] stall_q, bubble_q;

  // Counters see pre-edge handshake state, keep counting through flush, stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (dn_valid_q && !dn_ready_i && stall_q != '1)  stall_q  <= stall_q + CNT_W'(1);
      if (dn_ready_i && !dn_valid_q && bubble_q != '1) bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o  = stall_q;
  assign bubble_cnt_o = bubble_q;
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Bench for pipe_reg_hs: queue-based reference model compared every cycle, directed cases, random traffic.
// Build with PIPE_REG_HS_PERF_EN defined or not; counter expectations follow the same macro.
module tb_pipe_reg_hs;
  localparam int DW    = 32;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n, flush_i, up_valid_i, dn_ready_i;
  logic [DW-1:0]    default_data_i, up_data_i;
  logic             up_ready_o, dn_valid_o;
  logic [DW-1:0]    dn_data_o;
  logic [CNT_W-1:0] stall_cnt_o, bubble_cnt_o;

  pipe_reg_hs #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .default_data_i (default_data_i),
    .up_valid_i     (up_valid_i),
    .up_ready_o     (up_ready_o),
    .up_data_i      (up_data_i),
    .dn_valid_o     (dn_valid_o),
    .dn_ready_i     (dn_ready_i),
    .dn_data_o      (dn_data_o),
    .stall_cnt_o    (stall_cnt_o),
    .bubble_cnt_o   (bubble_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a FIFO of accepted-but-unconsumed beats, capacity two.
  logic [DW-1:0] q[$];
  logic [DW-1:0] last_data;
  int            m_stall, m_bubble;
  bit            model_ok = 0;

  always @(posedge clk) begin
    bit uf, df;
    if (!rst_n) begin
      q.delete();
      last_data = default_data_i;
      m_stall   = 0;
      m_bubble  = 0;
      model_ok  = 1;
    end else if (model_ok) begin
      uf = up_valid_i && (q.size() < 2);
      df = (q.size() > 0) && dn_ready_i;
      if (q.size() > 0 && !dn_ready_i && m_stall < CMAX)   m_stall++;
      if (q.size() == 0 && dn_ready_i && m_bubble < CMAX) m_bubble++;
      if (flush_i) begin
        q.delete();
        last_data = default_data_i;
      end else begin
        if (df) last_data = q.pop_front();
        if (uf) q.push_back(up_data_i);
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("dn_valid", 64'(dn_valid_o), 64'(q.size() > 0));
      check("up_ready", 64'(up_ready_o), 64'(q.size() < 2));
      check("dn_data", 64'(dn_data_o), 64'((q.size() > 0) ? q[0] : last_data));
`ifdef PIPE_REG_HS_PERF_EN
      check("stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
      check("bubble_cnt", 64'(bubble_cnt_o), 64'(m_bubble));
`else
      check("stall_cnt", 64'(stall_cnt_o), 64'd0);
      check("bubble_cnt", 64'(bubble_cnt_o), 64'd0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    up_valid_i = 1'b1;
    up_data_i  = d;
    step();
    up_valid_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; up_valid_i = 1'b0; dn_ready_i = 1'b0;
    up_data_i = '0; default_data_i = 32'hDEADBEEF;

    // Reset held two cycles
    step(); step();
    check("rst_dn_valid", 64'(dn_valid_o), 64'd0);
    check("rst_dn_data", 64'(dn_data_o), 64'hDEADBEEF);
    check("rst_up_ready", 64'(up_ready_o), 64'd1);
    check("rst_stall", 64'(stall_cnt_o), 64'd0);
    check("rst_bubble", 64'(bubble_cnt_o), 64'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back stream, each beat visible one cycle after acceptance
    dn_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(DW'(i));
      check("stream_data", 64'(dn_data_o), 64'(i));
      check("stream_valid", 64'(dn_valid_o), 64'd1);
      check("stream_ready", 64'(up_ready_o), 64'd1);
    end
    step();

    // Backpressure fills main then skid
    dn_ready_i = 1'b0;
    push(32'hA);
    push(32'hB);
    check("bp_ready_low", 64'(up_ready_o), 64'd0);
    check("bp_hold_a", 64'(dn_data_o), 64'hA);
    step();
    check("bp_still_a", 64'(dn_data_o), 64'hA);
    dn_ready_i = 1'b1;
    step();
    check("bp_then_b", 64'(dn_data_o), 64'hB);
    check("bp_ready_back", 64'(up_ready_o), 64'd1);
    step();
    check("bp_drained", 64'(dn_valid_o), 64'd0);

    // Flush while FULL, then back-to-back flush
    dn_ready_i = 1'b0;
    push(32'hA);
    push(32'hB);
    default_data_i = 32'h13;
    flush_i = 1'b1;
    step();
    check("fl_valid", 64'(dn_valid_o), 64'd0);
    check("fl_data", 64'(dn_data_o), 64'h13);
    check("fl_ready", 64'(up_ready_o), 64'd1);
    step();
    flush_i = 1'b0;
    dn_ready_i = 1'b1;
    step(); step();
    check("fl_nothing_left", 64'(dn_valid_o), 64'd0);
    check("fl_data_kept", 64'(dn_data_o), 64'h13);

    // Simultaneous up/dn fire in ONE keeps order
    push(32'hC);
    push(32'hD);
    check("sim_data_d", 64'(dn_data_o), 64'hD);
    check("sim_ready", 64'(up_ready_o), 64'd1);

    // Reset in the middle of FULL
    dn_ready_i = 1'b0;
    push(32'hE);
    push(32'hF);
    check("mid_full", 64'(up_ready_o), 64'd0);
    default_data_i = 32'h55;
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", 64'(dn_valid_o), 64'd0);
    check("mid_rst_ready", 64'(up_ready_o), 64'd1);
    check("mid_rst_data", 64'(dn_data_o), 64'h55);
    rst_n = 1'b1;

    // Stall counter saturation: one beat parked for 9 cycles
    push(32'h77);
    for (int i = 0; i < 9; i++) step();
`ifdef PIPE_REG_HS_PERF_EN
    check("perf_stall_sat", 64'(stall_cnt_o), 64'd7);
`else
    check("perf_stall_off", 64'(stall_cnt_o), 64'd0);
    check("perf_bubble_off", 64'(bubble_cnt_o), 64'd0);
`endif

    // Random traffic with occasional flush, reset and default changes
    for (int i = 0; i < 3000; i++) begin
      up_valid_i = ($urandom_range(0, 3) != 0);
      dn_ready_i = ($urandom_range(0, 2) != 0);
      up_data_i  = $urandom();
      flush_i    = ($urandom_range(0, 40) == 0);
      rst_n      = ($urandom_range(0, 250) != 0);
      if ($urandom_range(0, 15) == 0) default_data_i = $urandom();
      step();
    end
    rst_n = 1'b1; flush_i = 1'b0; up_valid_i = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
